// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: digit-serial adder that adds two operands DIGIT bits per cycle, LSB digit first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_adder_ctrl: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [DIGIT:0]   slice;

    assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                sum_d   = '0;
                cout_d  = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[cnt_q*DIGIT +: DIGIT] = slice[DIGIT-1:0];
                carry_d = slice[DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = slice[DIGIT];
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of serial_adder_ctrl against a+b+cin.
module tb_serial_adder_ctrl #(
    parameter int W = 8,
    parameter int D = 2
);
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    serial_adder_ctrl #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for the result, apply `stall` cycles of backpressure, then drain it.
    // With hold set, in_valid stays high and operands keep changing until the result handshake.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input int stall, input bit hold);
        logic [W:0]   model;
        int           edges;
        int           busy_cyc;
        model = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        chk("ready_before", in_ready, 1);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        tick();
        in_valid = hold;
        chk("busy_after_accept", busy, 1);
        chk("ready_in_run", in_ready, 0);
        edges = 0;
        busy_cyc = 0;
        while (!out_valid && edges < 4 * N + 10) begin
            if (busy) busy_cyc++;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            tick();
            edges++;
        end
        chk("latency", edges, N);
        chk("busy_cycles", busy_cyc, N);
        chk("sum", sum, model[W-1:0]);
        chk("cout", cout, model[W]);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", in_ready, 0);
            chk("stall_sum", sum, model[W-1:0]);
            chk("stall_cout", cout, model[W]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("idle_ready", in_ready, 1);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("held_sum", sum, model[W-1:0]);
        chk("held_cout", cout, model[W]);
    endtask

    initial begin
        logic [W-1:0] ones;
        ones = '1;
        tick();
        tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;
        tick();

        run_op(W'(8'h5A), W'(8'h3C), 1'b0, 0, 1'b0);
        run_op(W'(8'hFF), W'(8'h01), 1'b0, 0, 1'b0);
        run_op(ones, ones, 1'b1, 0, 1'b0);
        run_op('0, '0, 1'b1, 0, 1'b0);
        run_op(ones, '0, 1'b1, 0, 1'b0);
        run_op(W'(8'h12), W'(8'h34), 1'b1, 10, 1'b0);
        run_op(W'(8'hA5), W'(8'h5A), 1'b1, 2, 1'b1);

        // Abort an operation mid-flight; nothing may come out of it.
        in_valid = 1'b1;
        a = W'(8'hF0);
        b = W'(8'h0F);
        cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        for (int i = 0; i < N + 2; i++) begin
            tick();
            chk("abort_no_valid", out_valid, 0);
        end
        run_op(W'(8'h10), W'(8'h20), 1'b0, 0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                   1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
